// File: rtl/fetch_decode_unit.sv
// Fetch/decode front end for a 16x8 instruction memory with a 1-cycle registered read.
// Optional indirect operand fetch is enabled by defining FETCH_INDIRECT_EN.
//
//   state | meaning
//   F_REQ | instruction read strobe on mem_addr=pc
//   F_CAP | capture IR from memory, advance pc
//   DEC   | decode; pick direct or indirect operand path
//   I_REQ | operand pointer read strobe on IR[3:0]
//   I_CAP | capture effective address from memory
//   ISSUE | instr_valid high until the execute stage accepts
module fetch_decode_unit (
    input  logic       clk,
    input  logic       rst_n,
    output logic       mem_read,
    output logic [3:0] mem_addr,
    input  logic [7:0] mem_rdata,
    output logic       instr_valid,
    input  logic       instr_ready,
    output logic [2:0] opcode,
    output logic       ind,
    output logic       reg_ref,
    output logic [3:0] eff_addr,
    output logic [3:0] pc,
    input  logic       branch_en,
    input  logic [3:0] branch_addr
);

    typedef enum logic [2:0] {
        F_REQ,
        F_CAP,
        DEC,
`ifdef FETCH_INDIRECT_EN
        I_REQ,
        I_CAP,
`endif
        ISSUE
    } state_t;

    state_t     state;
    logic [7:0] ir;

    assign opcode  = ir[6:4];
    assign ind     = ir[7];
    assign reg_ref = (ir[6:4] == 3'b111);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= F_REQ;
            pc          <= 4'd0;
            ir          <= 8'd0;
            eff_addr    <= 4'd0;
            instr_valid <= 1'b0;
            mem_read    <= 1'b0;
            mem_addr    <= 4'd0;
        end else begin
            case (state)
                F_REQ: begin
                    // Out of reset the strobe is still low: raise it first, then consume the read.
                    if (mem_read) begin
                        mem_read <= 1'b0;
                        state    <= F_CAP;
                    end else begin
                        mem_read <= 1'b1;
                        mem_addr <= pc;
                    end
                end
                F_CAP: begin
                    ir    <= mem_rdata;
                    pc    <= pc + 4'd1;
                    state <= DEC;
                end
                DEC: begin
`ifdef FETCH_INDIRECT_EN
                    if (ir[7] && (ir[6:4] != 3'b111)) begin
                        mem_read <= 1'b1;
                        mem_addr <= ir[3:0];
                        state    <= I_REQ;
                    end else begin
                        eff_addr    <= ir[3:0];
                        instr_valid <= 1'b1;
                        state       <= ISSUE;
                    end
`else
                    eff_addr    <= ir[3:0];
                    instr_valid <= 1'b1;
                    state       <= ISSUE;
`endif
                end
`ifdef FETCH_INDIRECT_EN
                I_REQ: begin
                    mem_read <= 1'b0;
                    state    <= I_CAP;
                end
                I_CAP: begin
                    eff_addr    <= mem_rdata[3:0];
                    instr_valid <= 1'b1;
                    state       <= ISSUE;
                end
`endif
                ISSUE: begin
                    if (instr_ready) begin
                        instr_valid <= 1'b0;
                        mem_read    <= 1'b1;
                        state       <= F_REQ;
                        if (branch_en) begin
                            pc       <= branch_addr;
                            mem_addr <= branch_addr;
                        end else begin
                            mem_addr <= pc;
                        end
                    end
                end
                default: begin
                    instr_valid <= 1'b0;
                    mem_read    <= 1'b0;
                    state       <= F_REQ;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_fetch_decode_unit.sv
// Directed bench for fetch_decode_unit with a 1-cycle registered 16x8 memory model.
module tb_fetch_decode_unit;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       mem_read;
    logic [3:0] mem_addr;
    logic [7:0] mem_rdata = 8'd0;
    logic       instr_valid;
    logic       instr_ready;
    logic [2:0] opcode;
    logic       ind;
    logic       reg_ref;
    logic [3:0] eff_addr;
    logic [3:0] pc;
    logic       branch_en;
    logic [3:0] branch_addr;

    logic [7:0] mem [16];
    int checks = 0;
    int errors = 0;

`ifdef FETCH_INDIRECT_EN
    localparam int IND_LAT   = 5;
    localparam int IND_READS = 1;
    localparam logic [3:0] EA_F = 4'hA;
`else
    localparam int IND_LAT   = 3;
    localparam int IND_READS = 0;
    localparam logic [3:0] EA_F = 4'h8;
`endif

    fetch_decode_unit dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .mem_read    (mem_read),
        .mem_addr    (mem_addr),
        .mem_rdata   (mem_rdata),
        .instr_valid (instr_valid),
        .instr_ready (instr_ready),
        .opcode      (opcode),
        .ind         (ind),
        .reg_ref     (reg_ref),
        .eff_addr    (eff_addr),
        .pc          (pc),
        .branch_en   (branch_en),
        .branch_addr (branch_addr)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (mem_read) mem_rdata <= mem[mem_addr];
    end

    task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Waits for the fetch strobe, then counts cycles to instr_valid and checks the decoded result.
    task automatic do_fetch(input string tag, input logic [3:0] f_addr, input int lat,
                            input logic [2:0] op, input logic i, input logic rr,
                            input logic [3:0] ea, input logic [3:0] pcv,
                            input int nreads, input logic [3:0] raddr);
        int guard;
        int n;
        int reads;
        logic [3:0] last;
        guard = 0;
        while (!mem_read && guard < 20) begin
            @(negedge clk);
            guard++;
        end
        branch_en = 1'b0;
        check({tag, "_strobe"}, {7'd0, mem_read}, 8'd1);
        check({tag, "_faddr"}, {4'd0, mem_addr}, {4'd0, f_addr});
        n = 0;
        reads = 0;
        last = 4'd0;
        while (!instr_valid && n < 20) begin
            @(negedge clk);
            n++;
            if (mem_read) begin
                reads++;
                last = mem_addr;
            end
        end
        check({tag, "_latency"}, n[7:0], lat[7:0]);
        check({tag, "_opcode"}, {5'd0, opcode}, {5'd0, op});
        check({tag, "_ind"}, {7'd0, ind}, {7'd0, i});
        check({tag, "_reg_ref"}, {7'd0, reg_ref}, {7'd0, rr});
        check({tag, "_eff_addr"}, {4'd0, eff_addr}, {4'd0, ea});
        check({tag, "_pc"}, {4'd0, pc}, {4'd0, pcv});
        check({tag, "_reads"}, reads[7:0], nreads[7:0]);
        if (nreads > 0) check({tag, "_raddr"}, {4'd0, last}, {4'd0, raddr});
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_valid"}, {7'd0, instr_valid}, 8'd0);
        check({tag, "_mem_read"}, {7'd0, mem_read}, 8'd0);
        check({tag, "_mem_addr"}, {4'd0, mem_addr}, 8'd0);
        check({tag, "_pc"}, {4'd0, pc}, 8'd0);
        check({tag, "_eff_addr"}, {4'd0, eff_addr}, 8'd0);
        check({tag, "_opcode"}, {5'd0, opcode}, 8'd0);
    endtask

    initial begin
        for (int k = 0; k < 16; k++) mem[k] = 8'h00;
        mem[0]  = 8'h0C;
        mem[1]  = 8'h91;
        mem[2]  = 8'h26;
        mem[3]  = 8'h76;
        mem[5]  = 8'h05;
        mem[6]  = 8'hF6;
        mem[8]  = 8'h0A;
        mem[15] = 8'hC8;

        rst_n       = 1'b0;
        instr_ready = 1'b1;
        branch_en   = 1'b0;
        branch_addr = 4'h0;
        @(negedge clk);
        check_reset_outputs("reset");
        rst_n = 1'b1;

        do_fetch("i0", 4'h0, 3, 3'd0, 1'b0, 1'b0, 4'hC, 4'h1, 0, 4'h0);
        do_fetch("i1", 4'h1, IND_LAT, 3'd1, 1'b1, 1'b0, 4'h1, 4'h2, IND_READS, 4'h1);
        do_fetch("i2", 4'h2, 3, 3'd2, 1'b0, 1'b0, 4'h6, 4'h3, 0, 4'h0);
        @(negedge clk);
        instr_ready = 1'b0;
        do_fetch("i3", 4'h3, 3, 3'd7, 1'b0, 1'b1, 4'h6, 4'h4, 0, 4'h0);

        // Stall four cycles; branch_en without ready must not move pc.
        branch_en   = 1'b1;
        branch_addr = 4'h9;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            check("stall_valid", {7'd0, instr_valid}, 8'd1);
            check("stall_opcode", {5'd0, opcode}, 8'd7);
            check("stall_reg_ref", {7'd0, reg_ref}, 8'd1);
            check("stall_eff_addr", {4'd0, eff_addr}, 8'h6);
            check("stall_pc", {4'd0, pc}, 8'h4);
            check("stall_mem_read", {7'd0, mem_read}, 8'd0);
        end
        instr_ready = 1'b1;
        branch_addr = 4'hF;
        do_fetch("iF", 4'hF, IND_LAT, 3'd4, 1'b1, 1'b0, EA_F, 4'h0, IND_READS, 4'h8);
        do_fetch("wrap", 4'h0, 3, 3'd0, 1'b0, 1'b0, 4'hC, 4'h1, 0, 4'h0);

        // Abort the 0x91 fetch in its last pre-issue cycle with a reset pulse.
        begin
            int guard;
            guard = 0;
            while (!mem_read && guard < 20) begin
                @(negedge clk);
                guard++;
            end
            check("abort_faddr", {4'd0, mem_addr}, 8'h1);
            @(negedge clk);
            @(negedge clk);
`ifdef FETCH_INDIRECT_EN
            @(negedge clk);
            check("abort_ireq_strobe", {7'd0, mem_read}, 8'd1);
            check("abort_ireq_addr", {4'd0, mem_addr}, 8'h1);
            @(negedge clk);
`endif
            check("abort_pre_valid", {7'd0, instr_valid}, 8'd0);
            check("abort_pre_pc", {4'd0, pc}, 8'h2);
            rst_n = 1'b0;
            #1;
            check_reset_outputs("abort");
            @(negedge clk);
            rst_n = 1'b1;
        end
        do_fetch("restart", 4'h0, 3, 3'd0, 1'b0, 1'b0, 4'hC, 4'h1, 0, 4'h0);

        branch_en   = 1'b1;
        branch_addr = 4'h6;
        do_fetch("regref_ind", 4'h6, 3, 3'd7, 1'b1, 1'b1, 4'h6, 4'h7, 0, 4'h0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
